// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - AXI4-Lite master that programs FIR coefficients into the FIR register block
module fir_coef_loader #(
    parameter int C_M_AXI_ADDR_WIDTH = 16,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int FIR_COEF_WIDTH     = 18,
    parameter int MAX_COEFS          = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              coef_wr_en,
    input  logic [$clog2(MAX_COEFS)-1:0]      coef_wr_idx,
    input  logic [FIR_COEF_WIDTH-1:0]         coef_wr_data,
    input  logic [$clog2(MAX_COEFS):0]        coef_count,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     switches_val,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int CW = $clog2(MAX_COEFS);

    localparam logic [DW-1:0] FIR_ID   = DW'(32'h5F52_4946);
    localparam logic [AW-1:0] OFS_INFO = AW'(8'h00);
    localparam logic [AW-1:0] OFS_MAX  = AW'(8'h08);
    localparam logic [AW-1:0] OFS_SW   = AW'(8'h10);
    localparam logic [AW-1:0] OFS_NR   = AW'(8'h14);
    localparam logic [AW-1:0] OFS_COEF = AW'(8'h20);
    localparam logic [DW-1:0] SW_UPDATE = DW'(4);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_INFO = 3'd1,
        RD_MAX  = 3'd2,
        WR_NR   = 3'd3,
        WR_COEF = 3'd4,
        WR_SW   = 3'd5,
        FINISH  = 3'd6
    } state_t;

    state_t state, state_next;

    logic [FIR_COEF_WIDTH-1:0] coef_buf [MAX_COEFS];

    logic [CW:0]     cnt_lat;
    logic [DW-1:0]   sw_lat;
    logic [CW:0]     n_coefs;
    logic [CW-1:0]   coef_idx;

    // txn_issued: the transaction for the current state/index is in flight
    logic            txn_issued;
    logic            aw_acc;
    logic            w_acc;

    logic            aw_fire, w_fire, b_fire, ar_fire, r_fire;
    logic            is_wr, is_rd;
    logic            last_coef;
    logic            fail;
    logic [CW:0]     hw_max;
    logic [CW:0]     n_calc;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [AW-1:0]   rd_addr;
    logic [FIR_COEF_WIDTH-1:0] coef_rd;

    assign aw_fire = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_fire  = M_AXI_WVALID  & M_AXI_WREADY;
    assign b_fire  = M_AXI_BVALID  & M_AXI_BREADY;
    assign ar_fire = M_AXI_ARVALID & M_AXI_ARREADY;
    assign r_fire  = M_AXI_RVALID  & M_AXI_RREADY;

    assign is_wr = (state == WR_NR) || (state == WR_COEF) || (state == WR_SW);
    assign is_rd = (state == RD_INFO) || (state == RD_MAX);

    assign last_coef = ((CW+1)'({1'b0, coef_idx}) + (CW+1)'(1)) == n_coefs;

    assign busy = (state != IDLE) && (state != FINISH);
    assign done = (state == FINISH);

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    assign coef_rd = coef_buf[coef_idx];

    // Effective coefficient count: latched request clamped by the hardware tap count and buffer depth
    always_comb begin
        hw_max = (CW+1)'(MAX_COEFS);
        if (M_AXI_RDATA < DW'(MAX_COEFS)) begin
            hw_max = M_AXI_RDATA[CW:0];
        end
        n_calc = cnt_lat;
        if (hw_max < n_calc) begin
            n_calc = hw_max;
        end
    end

    // Address and payload for the transaction belonging to the current state
    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        unique case (state)
            WR_NR: begin
                wr_addr = BASE_ADDR + OFS_NR;
                wr_data = DW'(n_coefs);
            end
            WR_COEF: begin
                wr_addr = BASE_ADDR + OFS_COEF + AW'({coef_idx, 2'b00});
                wr_data = {{(DW-FIR_COEF_WIDTH){coef_rd[FIR_COEF_WIDTH-1]}}, coef_rd};
            end
            WR_SW: begin
                wr_addr = BASE_ADDR + OFS_SW;
                wr_data = sw_lat | SW_UPDATE;
            end
            default: begin
                wr_addr = '0;
                wr_data = '0;
            end
        endcase
        rd_addr = (state == RD_MAX) ? (BASE_ADDR + OFS_MAX) : (BASE_ADDR + OFS_INFO);
    end

    // Next-state selection; any bad response or identity mismatch aborts straight to FINISH
    always_comb begin
        state_next = state;
        fail       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = RD_INFO;
            end
            RD_INFO: begin
                if (r_fire) begin
                    if ((M_AXI_RDATA != FIR_ID) || (M_AXI_RRESP != 2'b00)) begin
                        state_next = FINISH;
                        fail       = 1'b1;
                    end else begin
                        state_next = RD_MAX;
                    end
                end
            end
            RD_MAX: begin
                if (r_fire) begin
                    if (M_AXI_RRESP != 2'b00) begin
                        state_next = FINISH;
                        fail       = 1'b1;
                    end else begin
                        state_next = WR_NR;
                    end
                end
            end
            WR_NR: begin
                if (b_fire) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        state_next = FINISH;
                        fail       = 1'b1;
                    end else if (n_coefs != '0) begin
                        state_next = WR_COEF;
                    end else begin
                        state_next = WR_SW;
                    end
                end
            end
            WR_COEF: begin
                if (b_fire) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        state_next = FINISH;
                        fail       = 1'b1;
                    end else if (last_coef) begin
                        state_next = WR_SW;
                    end
                end
            end
            WR_SW: begin
                if (b_fire) begin
                    state_next = FINISH;
                    fail       = (M_AXI_BRESP != 2'b00);
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Coefficient buffer; only writable while idle so a load sees a frozen image
    always_ff @(posedge M_AXI_ACLK) begin
        if ((state == IDLE) && coef_wr_en) begin
            coef_buf[coef_wr_idx] <= coef_wr_data;
        end
    end

    // AXI channel handshakes, request latching and the sticky error flag
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            error         <= 1'b0;
            cnt_lat       <= '0;
            sw_lat        <= '0;
            n_coefs       <= '0;
            coef_idx      <= '0;
            txn_issued    <= 1'b0;
            aw_acc        <= 1'b0;
            w_acc         <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                cnt_lat  <= coef_count;
                sw_lat   <= switches_val;
                error    <= 1'b0;
                coef_idx <= '0;
            end

            if (is_wr && !txn_issued) begin
                M_AXI_AWADDR  <= wr_addr;
                M_AXI_WDATA   <= wr_data;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                txn_issued    <= 1'b1;
            end

            if (is_rd && !txn_issued) begin
                M_AXI_ARADDR  <= rd_addr;
                M_AXI_ARVALID <= 1'b1;
                txn_issued    <= 1'b1;
            end

            if (aw_fire) begin
                M_AXI_AWVALID <= 1'b0;
                aw_acc        <= 1'b1;
            end
            if (w_fire) begin
                M_AXI_WVALID <= 1'b0;
                w_acc        <= 1'b1;
            end
            if ((aw_acc || aw_fire) && (w_acc || w_fire) && !M_AXI_BREADY) begin
                M_AXI_BREADY <= 1'b1;
            end
            if (b_fire) begin
                M_AXI_BREADY <= 1'b0;
                aw_acc       <= 1'b0;
                w_acc        <= 1'b0;
                txn_issued   <= 1'b0;
                if (state == WR_COEF) begin
                    coef_idx <= coef_idx + CW'(1);
                end
            end

            if (ar_fire) begin
                M_AXI_ARVALID <= 1'b0;
                M_AXI_RREADY  <= 1'b1;
            end
            if (r_fire) begin
                M_AXI_RREADY <= 1'b0;
                txn_issued   <= 1'b0;
                if (state == RD_MAX) begin
                    n_coefs <= n_calc;
                end
            end

            if (fail) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - randomized self-checking bench for fir_coef_loader
`timescale 1ns/1ps
module tb_fir_coef_loader;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int CWID = 18;
    localparam int MAXC = 32;
    localparam int IW   = 5;
    localparam logic [31:0] FIR_ID = 32'h5F52_4946;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            coef_wr_en   = 1'b0;
    logic [IW-1:0]   coef_wr_idx  = '0;
    logic [CWID-1:0] coef_wr_data = '0;
    logic [IW:0]     coef_count   = '0;
    logic [31:0]     switches_val = '0;
    logic            start        = 1'b0;
    logic            busy, done, error;

    logic [AW-1:0] awaddr;  logic [2:0] awprot; logic awvalid; logic awready = 1'b0;
    logic [DW-1:0] wdata;   logic [3:0] wstrb;  logic wvalid;  logic wready  = 1'b0;
    logic [1:0]    bresp = 2'b00; logic bvalid = 1'b0; logic bready;
    logic [AW-1:0] araddr;  logic [2:0] arprot; logic arvalid; logic arready = 1'b0;
    logic [DW-1:0] rdata = '0; logic [1:0] rresp = 2'b00; logic rvalid = 1'b0; logic rready;

    fir_coef_loader dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_idx   (coef_wr_idx),
        .coef_wr_data  (coef_wr_data),
        .coef_count    (coef_count),
        .switches_val  (switches_val),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // slave configuration and observation logs
    int          aw_dly = 0, w_dly = 0, err_idx = -1;
    logic [31:0] id_val = FIR_ID, max_val = 32;
    logic [15:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          rd_cnt = 0, stab_err = 0, done_cnt = 0;

    // slave internal state
    bit aw_fp, w_fp, b_fp, ar_fp, r_fp;
    bit aw_acc, w_acc, aw_seen, w_seen, ar_acc;
    int aw_cnt, w_cnt;
    logic [15:0] aw_hold, ar_hold;
    logic [31:0] w_hold;

    // reference model state
    logic [CWID-1:0] model_buf [MAXC];
    logic [15:0]     exp_addr [$];
    logic [31:0]     exp_data [$];
    bit              exp_err;
    int              exp_reads;

    int passed = 0, total = 0;

    // AXI4-Lite slave: drives its side at the falling edge, predicting handshakes of the next rising edge
    always @(negedge clk) begin
        if (rst) begin
            awready = 0; wready = 0; bvalid = 0; bresp = 0;
            arready = 0; rvalid = 0; rdata = 0; rresp = 0;
            aw_fp = 0; w_fp = 0; b_fp = 0; ar_fp = 0; r_fp = 0;
            aw_acc = 0; w_acc = 0; aw_seen = 0; w_seen = 0; ar_acc = 0;
            aw_cnt = 0; w_cnt = 0;
        end else begin
            if (aw_fp) begin awready = 0; aw_acc = 1; aw_fp = 0; end
            if (w_fp)  begin wready = 0;  w_acc = 1;  w_fp = 0;  end
            if (b_fp) begin
                bvalid = 0; b_fp = 0;
                wr_addr_q.push_back(aw_hold);
                wr_data_q.push_back(w_hold);
                aw_acc = 0; w_acc = 0; aw_seen = 0; w_seen = 0; aw_cnt = 0; w_cnt = 0;
            end
            if (ar_fp) begin arready = 0; ar_acc = 1; ar_fp = 0; end
            if (r_fp)  begin rvalid = 0; r_fp = 0; ar_acc = 0; rd_cnt++; end

            if (!aw_acc && !awready) begin
                if (awvalid) begin
                    if (!aw_seen) begin aw_seen = 1; aw_hold = awaddr; end
                    else if (awaddr !== aw_hold) stab_err++;
                    if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
                end else if (aw_seen) stab_err++;
            end
            if (!w_acc && !wready) begin
                if (wvalid) begin
                    if (!w_seen) begin w_seen = 1; w_hold = wdata; end
                    else if (wdata !== w_hold) stab_err++;
                    if (w_cnt >= w_dly) wready = 1; else w_cnt++;
                end else if (w_seen) stab_err++;
            end
            if (aw_acc && w_acc && !bvalid) begin
                bvalid = 1;
                bresp  = (wr_addr_q.size() == err_idx) ? 2'b10 : 2'b00;
            end

            if (!ar_acc && !arready && arvalid) begin
                ar_hold = araddr; arready = 1;
            end
            if (ar_acc && !rvalid) begin
                rvalid = 1; rresp = 2'b00;
                rdata  = (ar_hold == 16'h0000) ? id_val : (ar_hold == 16'h0008) ? max_val : 32'h0;
            end

            aw_fp = awvalid && awready;
            w_fp  = wvalid && wready;
            b_fp  = bvalid && bready;
            ar_fp = arvalid && arready;
            r_fp  = rvalid && rready;
        end
    end

    // count done pulses
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [31:0] sext(input logic [CWID-1:0] c);
        int v;
        v = int'(c);
        if (v >= 131072) v = v - 262144;
        return 32'(v);
    endfunction

    task automatic buf_write(input int idx, input logic [CWID-1:0] val);
        coef_wr_en = 1; coef_wr_idx = idx[IW-1:0]; coef_wr_data = val;
        model_buf[idx] = val;
        @(negedge clk);
        coef_wr_en = 0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) buf_write(i, CWID'($urandom));
    endtask

    // expected write list from the register map and load rules
    task automatic build_exp(input int cnt, input int hw_max, input logic [31:0] sw, input bit id_ok);
        int n;
        exp_addr.delete(); exp_data.delete();
        exp_err   = !id_ok;
        exp_reads = id_ok ? 2 : 1;
        if (id_ok) begin
            n = cnt;
            if (hw_max < n) n = hw_max;
            if (MAXC < n) n = MAXC;
            exp_addr.push_back(16'h0014); exp_data.push_back(32'(n));
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(16'(32 + 4 * i));
                exp_data.push_back(sext(model_buf[i]));
            end
            exp_addr.push_back(16'h0010); exp_data.push_back(sw | 32'h4);
            if (err_idx >= 0 && err_idx < exp_addr.size()) begin
                while (exp_addr.size() > err_idx + 1) begin
                    void'(exp_addr.pop_back());
                    void'(exp_data.pop_back());
                end
                exp_err = 1;
            end
        end
    endtask

    task automatic start_load(input int cnt, input logic [31:0] sw);
        wr_addr_q.delete(); wr_data_q.delete(); rd_cnt = 0; done_cnt = 0;
        coef_count = cnt[IW:0]; switches_val = sw; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        check({tag, " done"}, done, 1);
        check({tag, " busy low at done"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic compare_run(input string tag);
        int m;
        check({tag, " nwrites"}, wr_addr_q.size(), exp_addr.size());
        m = (wr_addr_q.size() < exp_addr.size()) ? wr_addr_q.size() : exp_addr.size();
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s wr%0d addr", tag, i), wr_addr_q[i], exp_addr[i]);
            check($sformatf("%s wr%0d data", tag, i), wr_data_q[i], exp_data[i]);
        end
        check({tag, " error"}, error, exp_err);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " reads"}, rd_cnt, exp_reads);
        check({tag, " stability"}, stab_err, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valids"}, {awvalid, wvalid, arvalid}, 0);
        check({tag, " readys"}, {bready, rready}, 0);
        check({tag, " status"}, {busy, done, error}, 0);
        check({tag, " addr"}, {awaddr, araddr}, 0);
        check({tag, " wdata"}, wdata, 0);
    endtask

    initial begin
        int cnt, k;
        logic [31:0] sw;

        rst = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset prot/strb", {awprot, arprot, wstrb}, 10'h00F);
        rst = 0;
        @(negedge clk);

        // happy path plus start and buffer writes while busy
        buf_write(0, 18'h00001); buf_write(1, 18'h3FFFF);
        buf_write(2, 18'h1FFFF); buf_write(3, 18'h20000);
        build_exp(4, 32, 32'h2, 1);
        start_load(4, 32'h2);
        check("happy busy", busy, 1);
        coef_count = 1; start = 1;
        coef_wr_en = 1; coef_wr_idx = 0; coef_wr_data = 18'h00155;
        @(negedge clk);
        start = 0; coef_wr_en = 0;
        wait_done("happy");
        compare_run("happy");

        // clamp to hardware tap count
        fill_random(MAXC);
        max_val = 8;
        sw = $urandom;
        build_exp(32, 8, sw, 1);
        start_load(32, sw);
        wait_done("clamp");
        compare_run("clamp");
        if (wr_addr_q.size() > 8) check("clamp last coef addr", wr_addr_q[8], 16'h003C);
        max_val = 32;

        // identity mismatch
        id_val = 32'h1234_5678;
        build_exp(4, 32, 32'h0, 0);
        start_load(4, 32'h0);
        wait_done("badid");
        compare_run("badid");
        id_val = FIR_ID;

        // backpressure on AW and W
        aw_dly = 3; w_dly = 5;
        cnt = $urandom_range(1, 10);
        sw = $urandom;
        build_exp(cnt, 32, sw, 1);
        start_load(cnt, sw);
        wait_done("bp");
        compare_run("bp");
        aw_dly = 0; w_dly = 0;

        // error response on the second coefficient write, then recovery
        err_idx = 2;
        build_exp(4, 32, 32'h1, 1);
        start_load(4, 32'h1);
        wait_done("bresp");
        compare_run("bresp");
        err_idx = -1;
        build_exp(2, 32, 32'h8, 1);
        start_load(2, 32'h8);
        check("restart clears error", error, 0);
        wait_done("restart");
        compare_run("restart");

        // zero coefficients
        build_exp(0, 32, 32'hFFFF_FFF0, 1);
        start_load(0, 32'hFFFF_FFF0);
        wait_done("count0");
        compare_run("count0");

        // buffer write coincident with start takes effect
        coef_wr_en = 1; coef_wr_idx = 0; coef_wr_data = 18'h2AAAA;
        model_buf[0] = 18'h2AAAA;
        build_exp(1, 32, 32'h0, 1);
        wr_addr_q.delete(); wr_data_q.delete(); rd_cnt = 0; done_cnt = 0;
        coef_count = 1; switches_val = 0; start = 1;
        @(negedge clk);
        start = 0; coef_wr_en = 0;
        wait_done("wr+start");
        compare_run("wr+start");

        // reset in the middle of coefficient writes
        aw_dly = 2;
        start_load(16, 32'h0);
        k = 0;
        while (wr_addr_q.size() < 3 && k < 2000) begin @(negedge clk); k++; end
        check("midreset reached coef writes", wr_addr_q.size() >= 3, 1);
        rst = 1;
        @(negedge clk);
        check_reset_outputs("midreset");
        @(negedge clk);
        rst = 0;
        aw_dly = 0;
        @(negedge clk);
        cnt = 3;
        build_exp(cnt, 32, 32'h5, 1);
        start_load(cnt, 32'h5);
        wait_done("postreset");
        compare_run("postreset");

        // randomized loads
        for (int r = 0; r < 4; r++) begin
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            for (int j = 0; j < 4; j++) buf_write($urandom_range(0, MAXC - 1), CWID'($urandom));
            cnt = $urandom_range(0, 40);
            max_val = $urandom_range(0, 40);
            sw = $urandom;
            build_exp(cnt, int'(max_val), sw, 1);
            start_load(cnt, sw);
            wait_done($sformatf("rand%0d", r));
            compare_run($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
